// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants and frame FSM state type.
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;
  typedef enum logic [1:0] {IDLE, RECV, DONE} ps2_state_e;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises ps2c/ps2d, debounces ps2c over FILTER_LEN samples and flags its falling edges.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_data,
  output logic o_clk,
  output logic o_fall_tick
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
  logic [1:0]    r_c_sync, r_d_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level, r_fall;
  logic          w_diff, w_flip;
  always_comb begin
    w_diff = r_c_sync[1] != r_level;
    w_flip = w_diff && r_cnt == LAST;
  end
  // r_cnt counts consecutive samples disagreeing with the filtered level
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_c_sync <= 2'b11;
      r_d_sync <= 2'b11;
      r_cnt    <= '0;
      r_level  <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2c};
      r_d_sync <= {r_d_sync[0], i_ps2d};
      r_cnt    <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_level  <= r_level ^ w_flip;
      r_fall   <= w_flip && r_level;
    end
  assign o_data      = r_d_sync[1];
  assign o_clk       = r_level;
  assign o_fall_tick = r_fall;
endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: PS/2 receiver emitting one validated key code per key release.
// Define PS2_PARITY_CHECK_EN to also reject frames whose odd parity is wrong.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int N              = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2d,
  input  logic         ps2c,
  output logic [N-1:0] key_code,
  output logic         got_code_tick,
  output logic         extended,
  output logic         frame_err
);
  localparam int SW = PS2_FRAME_BITS - 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  // frame_err then lands exactly TIMEOUT_CYCLES clk after the last fall_tick
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 2);
  ps2_state_e    r_state, w_next;
  logic [SW-1:0] r_shift;
  logic [3:0]    r_bits;
  logic [WW-1:0] r_wdog;
  logic          r_brk, r_ext;
  logic          w_data, w_fall, w_unused_fclk;
  logic          w_recv_bit, w_timeout, w_valid, w_good, w_is_brk, w_is_ext, w_tick, w_err;
  logic [7:0]    w_byte;
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .reset      (reset),
    .i_ps2c     (ps2c),
    .i_ps2d     (ps2d),
    .o_data     (w_data),
    .o_clk      (w_unused_fclk),
    .o_fall_tick(w_fall)
  );
  always_comb begin
    w_recv_bit = r_state == RECV && w_fall;
    w_timeout  = r_state == RECV && !w_fall && r_wdog == WD_LAST;
`ifdef PS2_PARITY_CHECK_EN
    w_valid    = r_shift[SW-1] && ^r_shift[SW-2:0];
`else
    w_valid    = r_shift[SW-1];
`endif
    w_byte     = r_shift[7:0];
    w_good     = r_state == DONE && w_valid;
    w_is_brk   = w_byte == PS2_BREAK_CODE;
    w_is_ext   = w_byte == PS2_EXT_CODE;
    w_tick     = w_good && !w_is_brk && !w_is_ext && r_brk;
    w_err      = (r_state == DONE && !w_valid) || w_timeout;
    w_next     = r_state;
    case (r_state)
      IDLE:    w_next = (w_fall && !w_data) ? RECV : IDLE;
      RECV:    w_next = w_timeout ? IDLE : (w_recv_bit && r_bits == 4'(SW - 1)) ? DONE : RECV;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // break/extended prefixes may arrive in either order before the key byte
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_shift       <= '0;
      r_bits        <= '0;
      r_wdog        <= '0;
      r_brk         <= 1'b0;
      r_ext         <= 1'b0;
      got_code_tick <= 1'b0;
      frame_err     <= 1'b0;
      key_code      <= '0;
      extended      <= 1'b0;
    end else begin
      r_shift       <= w_recv_bit ? {w_data, r_shift[SW-1:1]} : r_shift;
      r_bits        <= r_state != RECV ? '0 : r_bits + 4'(w_fall);
      r_wdog        <= (r_state != RECV || w_fall) ? '0 : r_wdog + 1'b1;
      r_brk         <= w_err ? 1'b0 : w_good ? (w_is_brk || (w_is_ext && r_brk)) : r_brk;
      r_ext         <= w_err ? 1'b0 : w_good ? (w_is_ext || (w_is_brk && r_ext)) : r_ext;
      got_code_tick <= w_tick;
      frame_err     <= w_err;
      key_code      <= w_tick ? N'(w_byte) : key_code;
      extended      <= w_tick ? r_ext : extended;
    end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: drives PS/2 frames at pin level and checks every cycle against a frame-level event model.
module tb_ps2_scan_decoder;
  localparam int F = 8;
  localparam int T = 400;
  typedef struct {
    int         at;
    bit         err;
    logic [7:0] code;
    bit         ext;
  } ev_t;
  logic clk = 1'b0, reset = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
  logic [7:0] key_code;
  logic got_code_tick, extended, frame_err;
  ev_t q[$];
  int cyc = 0, vectors = 0, miscompares = 0, ticks = 0, errs = 0, last_fall = 0;
  bit m_brk = 1'b0, m_ext = 1'b0, m_kext = 1'b0, exp_tick, exp_err;
  logic [7:0] m_key = 8'h00;

  ps2_scan_decoder #(.N(8), .FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .key_code     (key_code),
    .got_code_tick(got_code_tick),
    .extended     (extended),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Each output event is due a fixed number of clk after the pin edge that completes its frame.
  always @(posedge clk) begin
    cyc++;
    #1;
    exp_tick = 1'b0;
    exp_err  = 1'b0;
    if (reset && q.size() > 0 && q[0].at == cyc) begin
      exp_err  = q[0].err;
      exp_tick = !q[0].err;
      if (exp_tick) begin
        m_key  = q[0].code;
        m_kext = q[0].ext;
      end
      void'(q.pop_front());
    end
    vectors++;
    if ({got_code_tick, frame_err, key_code, extended} !== {exp_tick, exp_err, m_key, m_kext}) begin
      miscompares++;
      $display("FAIL outputs @cycle %0d: tick=%b err=%b key=%h ext=%b, expected tick=%b err=%b key=%h ext=%b",
               cyc, got_code_tick, frame_err, key_code, extended, exp_tick, exp_err, m_key, m_kext);
    end
    ticks += int'(got_code_tick);
    errs  += int'(frame_err);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int at, input bit err, input logic [7:0] code, input bit ext);
    ev_t e;
    e.at = at;
    e.err = err;
    e.code = code;
    e.ext = ext;
    q.push_back(e);
  endtask

  task automatic post_frame(input logic [7:0] b, input bit ok, input int at);
    if (!ok) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
      push_ev(at, 1'b1, 8'h00, 1'b0);
    end else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (m_brk) push_ev(at, 1'b0, b, m_ext);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  // One clock phase; an optional glitch of F-1 clk lands after the filter has settled.
  task automatic phase(input int half, input bit glitch, input logic lvl);
    for (int k = 0; k < half; k++) begin
      @(negedge clk);
      if (glitch && k == 11) ps2c = ~lvl;
      if (glitch && k == 10 + F) ps2c = lvl;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int half, input bit glitch);
    logic [10:0] fr;
    bit ok;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    ok = !bad_stop && !bad_par;
`else
    ok = !bad_stop;
`endif
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      phase(half, glitch, 1'b1);
      ps2c = 1'b0;
      last_fall = cyc;
      if (i == 10) post_frame(b, ok, cyc + 4 + F);
      phase(half, glitch, 1'b0);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    gap(12);
  endtask

  task automatic frame(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, 16, 1'b0);
  endtask

  task automatic timeout_frame(input logic [7:0] b, input int nbits, input int half);
    send_frame(b, 1'b0, 1'b0, nbits, half, 1'b0);
    m_brk = 1'b0;
    m_ext = 1'b0;
    push_ev(last_fall + 2 + F + T, 1'b1, 8'h00, 1'b0);
    gap(T + 20);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    ps2c = 1'b1;
    ps2d = 1'b1;
    q.delete();
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_key = 8'h00;
    m_kext = 1'b0;
    #1;
    chk("async reset key_code", key_code, 32'h0);
    chk("async reset extended", extended, 32'h0);
    chk("async reset tick", got_code_tick, 32'h0);
    chk("async reset frame_err", frame_err, 32'h0);
    gap(3);
    reset = 1'b1;
    gap(10);
  endtask

  initial begin
    logic [7:0] b;
    int h, p, t0, e0;
    gap(5);
    reset = 1'b1;
    gap(20);
    chk("reset key_code", key_code, 32'h0);
    chk("reset extended", extended, 32'h0);
    t0 = ticks;
    frame(8'h05); frame(8'hF0); frame(8'h05);
    chk("05 F0 05 ticks", ticks - t0, 1);
    chk("05 F0 05 key_code", key_code, 32'h05);
    chk("05 F0 05 extended", extended, 32'h0);
    t0 = ticks;
    frame(8'hE0); frame(8'h75); frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("E0 F0 75 ticks", ticks - t0, 1);
    chk("E0 F0 75 key_code", key_code, 32'h75);
    chk("E0 F0 75 extended", extended, 32'h1);
    t0 = ticks;
    e0 = errs;
    frame(8'hF0);
    send_frame(8'h79, 1'b1, 1'b0, 11, 16, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("bad parity frame_err", errs - e0, 1);
    chk("bad parity ticks", ticks - t0, 0);
    chk("bad parity key_code", key_code, 32'h75);
    frame(8'h79);
    chk("flags cleared after error", ticks - t0, 0);
`else
    chk("ignored parity ticks", ticks - t0, 1);
    chk("ignored parity key_code", key_code, 32'h79);
    chk("ignored parity frame_err", errs - e0, 0);
`endif
    e0 = errs;
    timeout_frame(8'h33, 5, 16);
    chk("timeout frame_err", errs - e0, 1);
    t0 = ticks;
    frame(8'hF0); frame(8'h06);
    chk("after timeout ticks", ticks - t0, 1);
    chk("after timeout key_code", key_code, 32'h06);
    t0 = ticks;
    send_frame(8'hF0, 1'b0, 1'b0, 11, 22, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 22, 1'b1);
    chk("glitched ticks", ticks - t0, 1);
    chk("glitched key_code", key_code, 32'h1C);
    e0 = errs;
    send_frame(8'h2A, 1'b0, 1'b1, 11, 22, 1'b1);
    chk("stop 0 frame_err", errs - e0, 1);
    frame(8'hF0);
    send_frame(8'h04, 1'b0, 1'b0, 5, 16, 1'b0);
    ps2d = 1'b0;
    gap(3);
    reset_pulse();
    t0 = ticks;
    frame(8'hF0); frame(8'h04);
    chk("after reset ticks", ticks - t0, 1);
    chk("after reset key_code", key_code, 32'h04);
    for (int n = 0; n < 70; n++) begin
      p = $urandom_range(0, 9);
      b = p < 3 ? 8'hF0 : p < 5 ? 8'hE0 : 8'($urandom_range(0, 255));
      h = $urandom_range(12, 24);
      if ($urandom_range(0, 24) == 0) timeout_frame(b, $urandom_range(1, 10), h);
      else send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, 11, h,
                      h >= 20 && $urandom_range(0, 1) == 1);
    end
    gap(30);
    chk("pending events drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
